// File: rtl/button_pkg.sv
// Shared types and helpers for the button event block: widths, event record, priority encoder.
// Combinational only; no latency or backpressure of its own.
package button_pkg;

    localparam int MAX_BTN = 15;
    localparam int IDX_W   = 5;

    function automatic int btn_w(input int n_btn);
        return $clog2(n_btn) + 1;
    endfunction

    function automatic logic [IDX_W-1:0] none_idx(input int n_btn);
        return IDX_W'((1 << btn_w(n_btn)) - 1);
    endfunction

    typedef struct packed {
        logic             press;
        logic [IDX_W-1:0] idx;
    } event_t;

    // Result is {found, index}; scanning downwards leaves the lowest set index.
    function automatic logic [IDX_W:0] prio_enc(input logic [MAX_BTN-1:0] v);
        logic [IDX_W:0] r;
        r = '0;
        for (int i = MAX_BTN - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = {1'b1, IDX_W'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/button_events_debounce.sv
// One button: 2-FF synchroniser, stability counter and stable bit; stable bit flips DEBOUNCE_CYCLES+1 edges after sampling.
// No backpressure; changed is a combinational strobe for the edge on which the stable bit flips.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16384
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic pressed,
    output logic changed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          s_q, s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flip;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        s_d     = s_q;
        cnt_d   = '0;
        flip    = 1'b0;
        if (sync2_q != s_q) begin
            if (cnt_q == CNT_LAST) begin
                flip = 1'b1;
                s_d  = ~s_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Raw level is active-low, so everything resets to 1 (released).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            s_q     <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pressed = ~s_q;
    assign changed = flip;

endmodule

// File: rtl/button_events.sv
// Debounced buttons -> held index plus press/release event FIFO; events enter the FIFO one edge after the debounced flip.
// A full FIFO holds events in the pending mask; a second flip of a still-pending button drops both and sets ev_lost.
module button_events
    import button_pkg::*;
#(
    parameter int N_BTN           = 8,
    parameter int DEBOUNCE_CYCLES = 16384,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_BTN-1:0]         btn,
    output logic [N_BTN-1:0]         btn_state,
    output logic [$clog2(N_BTN):0]   button,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic                     ev_press,
    output logic [$clog2(N_BTN):0]   ev_btn,
    output logic                     ev_lost,
    input  logic                     ev_lost_clr
);

    localparam int BTN_W = btn_w(N_BTN);
    localparam logic [BTN_W-1:0] NONE = {BTN_W{1'b1}};
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [N_BTN-1:0]   s_press;
    logic [N_BTN-1:0]   changed;

    for (genvar g = 0; g < N_BTN; g++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_raw(btn[g]),
            .pressed(s_press[g]),
            .changed(changed[g])
        );
    end

    logic [BTN_W-1:0]   button_q, button_d;
    logic [N_BTN-1:0]   pend_q, pend_d;
    logic [N_BTN-1:0]   pend_base, pend_clr;
    logic               ev_lost_q, ev_lost_d;
    logic [AW:0]        wr_q, wr_d, rd_q, rd_d;
    event_t             mem_q [FIFO_DEPTH];
    event_t             mem_d [FIFO_DEPTH];
    event_t             push_ev, head;
    logic [IDX_W:0]     held_enc, pend_enc;
    logic               empty, full, push, pop, lost;

    assign held_enc = prio_enc(MAX_BTN'(s_press));
    assign pend_enc = prio_enc(MAX_BTN'(pend_q));
    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head     = mem_q[rd_q[AW-1:0]];

    always_comb begin
        button_d = held_enc[IDX_W] ? held_enc[BTN_W-1:0] : NONE;

        push = !full && (|pend_q);
        pop  = !empty && ev_ready;
        for (int i = 0; i < N_BTN; i++) begin
            pend_clr[i] = push && (pend_enc[IDX_W-1:0] == IDX_W'(i));
        end
        push_ev.press = |(s_press & pend_clr);
        push_ev.idx   = pend_enc[IDX_W-1:0];

        // A flip on a bit that is still pending after this cycle's push cancels it.
        pend_base = pend_q & ~pend_clr;
        pend_d    = pend_base ^ changed;
        lost      = |(pend_base & changed);
        ev_lost_d = lost | (ev_lost_q & ~ev_lost_clr);

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_q[AW-1:0]] = push_ev;
        end
        wr_d = wr_q + {{AW{1'b0}}, push};
        rd_d = rd_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            button_q  <= NONE;
            pend_q    <= '0;
            ev_lost_q <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            button_q  <= button_d;
            pend_q    <= pend_d;
            ev_lost_q <= ev_lost_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            mem_q     <= mem_d;
        end
    end

    assign btn_state = s_press;
    assign button    = button_q;
    assign ev_valid  = !empty;
    assign ev_press  = ev_valid & head.press;
    assign ev_btn    = ev_valid ? head.idx[BTN_W-1:0] : '0;
    assign ev_lost   = ev_lost_q;

    logic unused_bits;
    assign unused_bits = ^{head.idx, held_enc, pend_enc};

endmodule

// File: tb/tb_button_events.sv
// Scoreboarded bench for button_events with N_BTN=8, DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
module tb_button_events;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] btn = 8'hFF;
    logic       ev_ready = 1'b1;
    logic       ev_lost_clr = 1'b0;
    logic [7:0] btn_state;
    logic [3:0] button;
    logic       ev_valid;
    logic       ev_press;
    logic [3:0] ev_btn;
    logic       ev_lost;

    int n_cmp = 0;
    int n_err = 0;
    logic [4:0] sb_q[$];
    logic [4:0] mon_exp;

    button_events #(
        .N_BTN(8), .DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .btn_state(btn_state), .button(button),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_press(ev_press), .ev_btn(ev_btn),
        .ev_lost(ev_lost), .ev_lost_clr(ev_lost_clr)
    );

    always #5 clk = ~clk;

    // Every accepted event is checked against the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && ev_valid && ev_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL ev_unexpected: got press=%0d btn=%0d, required no event", ev_press, ev_btn);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({ev_press, ev_btn} !== mon_exp) begin
                    n_err++;
                    $display("FAIL ev_order: got press=%0d btn=%0d, required press=%0d btn=%0d",
                             ev_press, ev_btn, mon_exp[4], mon_exp[3:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        btn   = 8'hFF;
        cyc(3);
        n_cmp++; if (button !== 4'd15) begin n_err++; $display("FAIL rst_button: got %0d, required 15", button); end
        n_cmp++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL rst_ev_valid: got %0d, required 0", ev_valid); end
        n_cmp++; if (btn_state !== 8'h00) begin n_err++; $display("FAIL rst_btn_state: got %h, required 00", btn_state); end
        n_cmp++; if ({ev_press, ev_btn, ev_lost} !== 6'd0) begin n_err++; $display("FAIL rst_ev_fields: got press=%0d btn=%0d lost=%0d, required 0/0/0", ev_press, ev_btn, ev_lost); end
        rst_n = 1'b1;
        cyc(3);
        n_cmp++; if (button !== 4'd15 || ev_valid !== 1'b0 || btn_state !== 8'h00) begin
            n_err++; $display("FAIL idle_after_rst: got button=%0d valid=%0d state=%h, required 15/0/00", button, ev_valid, btn_state);
        end
    endtask

    task automatic test_clean_press;
        btn[3] = 1'b0;
        sb_q.push_back({1'b1, 4'd3});
        cyc(5);
        n_cmp++; if (btn_state !== 8'h00) begin n_err++; $display("FAIL press_early: got %h, required 00", btn_state); end
        cyc(1);
        n_cmp++; if (btn_state !== 8'h08) begin n_err++; $display("FAIL press_state_e5: got %h, required 08", btn_state); end
        n_cmp++; if (button !== 4'd15) begin n_err++; $display("FAIL press_button_e5: got %0d, required 15", button); end
        cyc(1);
        n_cmp++; if (button !== 4'd3) begin n_err++; $display("FAIL press_button_e6: got %0d, required 3", button); end
        n_cmp++; if (ev_valid !== 1'b1) begin n_err++; $display("FAIL press_valid_e6: got %0d, required 1", ev_valid); end
        cyc(13);
        btn[3] = 1'b1;
        sb_q.push_back({1'b0, 4'd3});
        cyc(5);
        n_cmp++; if (btn_state !== 8'h08) begin n_err++; $display("FAIL release_early: got %h, required 08", btn_state); end
        cyc(1);
        n_cmp++; if (btn_state !== 8'h00) begin n_err++; $display("FAIL release_state: got %h, required 00", btn_state); end
        cyc(1);
        n_cmp++; if (button !== 4'd15) begin n_err++; $display("FAIL release_button: got %0d, required 15", button); end
        cyc(4);
        n_cmp++; if (sb_q.size() !== 0) begin n_err++; $display("FAIL press_drained: got %0d left, required 0", sb_q.size()); end
    endtask

    task automatic test_glitch;
        btn[2] = 1'b0;
        cyc(3);
        btn[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            n_cmp++;
            if (btn_state !== 8'h00 || ev_valid !== 1'b0) begin
                n_err++; $display("FAIL glitch_%0d: got state=%h valid=%0d, required 00/0", i, btn_state, ev_valid);
            end
        end
    endtask

    task automatic test_simultaneous;
        btn[5] = 1'b0;
        btn[1] = 1'b0;
        sb_q.push_back({1'b1, 4'd1});
        sb_q.push_back({1'b1, 4'd5});
        cyc(7);
        n_cmp++; if (button !== 4'd1) begin n_err++; $display("FAIL simul_button: got %0d, required 1", button); end
        n_cmp++; if (btn_state !== 8'h22) begin n_err++; $display("FAIL simul_state: got %h, required 22", btn_state); end
        cyc(5);
        btn[1] = 1'b1;
        btn[5] = 1'b1;
        sb_q.push_back({1'b0, 4'd1});
        sb_q.push_back({1'b0, 4'd5});
        cyc(12);
        n_cmp++; if (button !== 4'd15) begin n_err++; $display("FAIL simul_release: got %0d, required 15", button); end
        n_cmp++; if (sb_q.size() !== 0) begin n_err++; $display("FAIL simul_drained: got %0d left, required 0", sb_q.size()); end
    endtask

    task automatic test_backpressure;
        ev_ready = 1'b0;
        btn = 8'hC0;
        for (int i = 0; i < 6; i++) sb_q.push_back({1'b1, 4'(i)});
        cyc(12);
        n_cmp++; if (dut.pend_q !== 8'h30) begin n_err++; $display("FAIL bp_pend: got %h, required 30", dut.pend_q); end
        n_cmp++; if (ev_lost !== 1'b0) begin n_err++; $display("FAIL bp_lost: got %0d, required 0", ev_lost); end
        n_cmp++; if ({ev_valid, ev_press, ev_btn} !== 6'b11_0000) begin n_err++; $display("FAIL bp_head: got v=%0d p=%0d b=%0d, required 1/1/0", ev_valid, ev_press, ev_btn); end
        cyc(3);
        n_cmp++; if ({ev_valid, ev_press, ev_btn} !== 6'b11_0000) begin n_err++; $display("FAIL bp_head_stable: got v=%0d p=%0d b=%0d, required 1/1/0", ev_valid, ev_press, ev_btn); end
        ev_ready = 1'b1;
        cyc(10);
        n_cmp++; if (sb_q.size() !== 0 || ev_valid !== 1'b0 || dut.pend_q !== 8'h00) begin
            n_err++; $display("FAIL bp_drain: got left=%0d valid=%0d pend=%h, required 0/0/00", sb_q.size(), ev_valid, dut.pend_q);
        end
        // Second round is cut short by reset while the FIFO is full.
        ev_ready = 1'b0;
        btn = 8'hFF;
        for (int i = 0; i < 6; i++) sb_q.push_back({1'b0, 4'(i)});
        cyc(12);
        n_cmp++; if (dut.pend_q !== 8'h30 || ev_valid !== 1'b1) begin n_err++; $display("FAIL bp2_full: got pend=%h valid=%0d, required 30/1", dut.pend_q, ev_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %0d, required 0", ev_valid); end
        n_cmp++; if (dut.pend_q !== 8'h00) begin n_err++; $display("FAIL midrst_pend: got %h, required 00", dut.pend_q); end
        sb_q.delete();
        cyc(2);
        rst_n = 1'b1;
        ev_ready = 1'b1;
        cyc(4);
        n_cmp++; if (ev_valid !== 1'b0 || button !== 4'd15 || btn_state !== 8'h00) begin
            n_err++; $display("FAIL midrst_idle: got valid=%0d button=%0d state=%h, required 0/15/00", ev_valid, button, btn_state);
        end
    endtask

    task automatic test_loss;
        ev_ready = 1'b0;
        btn = 8'h0F;
        for (int i = 4; i < 8; i++) sb_q.push_back({1'b1, 4'(i)});
        cyc(12);
        n_cmp++; if (ev_valid !== 1'b1 || dut.pend_q !== 8'h00) begin n_err++; $display("FAIL loss_fill: got valid=%0d pend=%h, required 1/00", ev_valid, dut.pend_q); end
        btn[0] = 1'b0;
        cyc(8);
        n_cmp++; if (dut.pend_q !== 8'h01) begin n_err++; $display("FAIL loss_pend_set: got %h, required 01", dut.pend_q); end
        btn[0] = 1'b1;
        cyc(8);
        n_cmp++; if (dut.pend_q !== 8'h00) begin n_err++; $display("FAIL loss_pend_clr: got %h, required 00", dut.pend_q); end
        n_cmp++; if (ev_lost !== 1'b1) begin n_err++; $display("FAIL loss_flag: got %0d, required 1", ev_lost); end
        n_cmp++; if (btn_state !== 8'hF0) begin n_err++; $display("FAIL loss_state: got %h, required F0", btn_state); end
        cyc(2);
        n_cmp++; if (ev_lost !== 1'b1) begin n_err++; $display("FAIL loss_sticky: got %0d, required 1", ev_lost); end
        ev_lost_clr = 1'b1;
        cyc(1);
        ev_lost_clr = 1'b0;
        n_cmp++; if (ev_lost !== 1'b0) begin n_err++; $display("FAIL loss_clear: got %0d, required 0", ev_lost); end
        ev_ready = 1'b1;
        cyc(8);
        n_cmp++; if (sb_q.size() !== 0) begin n_err++; $display("FAIL loss_drained: got %0d left, required 0", sb_q.size()); end
        btn = 8'hFF;
        for (int i = 4; i < 8; i++) sb_q.push_back({1'b0, 4'(i)});
        cyc(14);
        n_cmp++; if (sb_q.size() !== 0 || ev_lost !== 1'b0) begin n_err++; $display("FAIL loss_final: got left=%0d lost=%0d, required 0/0", sb_q.size(), ev_lost); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_simultaneous();
        test_backpressure();
        test_loss();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/button_events.md
# button_events

Parametrised successor to the badge's button-number encoder. Synchronises and debounces `N_BTN` active-low buttons, keeps a priority-encoded "currently held" index, and queues press/release events in a small FIFO with a valid/ready handshake. Sits between the badge button pins and the audio/CPU consumers. Consumers poll `button` for level state or drain the event stream.

## Interface
- `N_BTN`, 8: number of buttons (1..15).
- `DEBOUNCE_CYCLES`, 16384: consecutive stable cycles required to accept a change (≥1).
- `FIFO_DEPTH`, 4: event FIFO entries (power of two, ≥2).
- Derived `BTN_W = $clog2(N_BTN)+1`; `NONE = {BTN_W{1'b1}}` (15 for `N_BTN`=8).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn` in `N_BTN`: raw buttons, asynchronous, 0 = pressed.
- `btn_state` out `N_BTN`: debounced state, 1 = pressed.
- `button` out `BTN_W`: lowest-index debounced pressed button, else `NONE`.
- `ev_valid` out 1: FIFO head valid.
- `ev_ready` in 1: consumer accepts head.
- `ev_press` out 1: head event type, 1 = press, 0 = release.
- `ev_btn` out `BTN_W`: head event button index.
- `ev_lost` out 1: sticky, set when an event was lost.
- `ev_lost_clr` in 1: clears `ev_lost`.

## Operation
- **Synchroniser.** Each `btn` bit passes a 2-FF synchroniser; the FFs reset to 1 (released).
- **Debounce.**
  - Per button: stable bit `s[i]` plus counter `cnt[i]` of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - When the synchronised value equals `s[i]`, `cnt` returns to 0.
  - Otherwise `cnt` increments. On the edge where `cnt == DEBOUNCE_CYCLES-1`, `s[i]` flips and `cnt` returns to 0.
  - Glitches shorter than `DEBOUNCE_CYCLES` are never accepted. `btn_state = s`.
- **Held encoder.** `button` is registered from `s` as the lowest set index, or `NONE` when no bit is set.
- **Pending mask.**
  - A flip of `s[i]` toggles `pend[i]`.
  - A second flip while `pend[i]` is still set clears `pend[i]`; both events are dropped and `ev_lost` is set.
- **Event push.**
  - Each cycle where the FIFO is not full at cycle start and `pend` is nonzero, the lowest pending index `j` is written as {`s[j]`, `j`}, and `pend[j]` is cleared.
  - A full FIFO back-pressures: pending bits are held, not lost.
  - Lower index wins on simultaneous changes; the others follow on consecutive cycles.
- **FIFO.**
  - Show-ahead: `ev_*` reflect the head whenever `ev_valid` = 1.
  - Pop on `ev_valid && ev_ready`.
  - No write-through bypass: a write to an empty FIFO raises `ev_valid` on the following cycle.
  - Push and pop in the same cycle are both performed. Push eligibility uses the full flag from cycle start, so a full FIFO that pops accepts no push that cycle.
  - Read and write pointers wrap modulo `FIFO_DEPTH`; an extra wrap bit distinguishes full from empty.
- **`ev_lost`.** If `ev_lost_clr` and a new loss occur in the same cycle, set wins.

## Timing
- **Reset values:** synchronisers and `s` = released; `cnt`=0; `pend`=0; FIFO empty; `btn_state`=0; `button`=`NONE`; `ev_valid`=0; `ev_press`=0; `ev_btn`=0; `ev_lost`=0.
- **Reset mid-operation:** asynchronous assertion empties the FIFO and discards pending events immediately.
- **Latency.** Let edge E0 be the first edge sampling a held change:
  - `btn_state` and `pend` update at E0+`DEBOUNCE_CYCLES`+1.
  - `button` updates and the FIFO write occur at E0+`DEBOUNCE_CYCLES`+2.
  - `ev_valid` is high after that edge if the FIFO was empty.
- **Throughput:** one push and one pop per cycle.
- **Handshake:** `ev_press` and `ev_btn` stay stable while `ev_valid && !ev_ready`.

## Structure
- **Shared package `button_pkg`:**
  - `BTN_W` and `NONE` functions of `N_BTN`.
  - Event struct {press, idx}.
  - Priority-encode function, shared by `button` and push selection.
- **Sub-module `btn_debounce`:** one button's synchroniser, counter and stable bit, with a one-cycle `changed` strobe. Instantiated `N_BTN` times in a generate loop.
- **FIFO:** stays inline as a register array.

## Test plan
All scenarios use `N_BTN`=8, `DEBOUNCE_CYCLES`=4, `FIFO_DEPTH`=4.
- **Reset/idle.** Hold `rst_n`=0 with buttons released; release reset → `button`=15, `ev_valid`=0, `btn_state`=0.
- **Clean press.** Press `btn[3]` for 20 cycles, then release → `btn_state[3]` rises at E0+5, `button`=3 at E0+6, events {1,3} then {0,3}.
- **Glitch.** Pulse `btn[2]` low for 3 cycles → no `btn_state` change, no event.
- **Simultaneous press.** Press `btn[5]` and `btn[1]` together → `button`=1; events {1,1} then {1,5} on consecutive pushes.
- **Backpressure and mid-operation reset.**
  - Hold `ev_ready`=0 and generate 6 events → 4 queued, 2 held in `pend`, `ev_lost`=0.
  - Raise `ev_ready` → all 6 drain in order.
  - Repeat, asserting `rst_n`=0 mid-stream → FIFO empty, `ev_valid`=0 immediately.
- **Loss.** With the FIFO full, press then release `btn[0]` → `pend[0]` returns to 0 and `ev_lost`=1. Assert `ev_lost_clr` in a later cycle with no new loss → `ev_lost` clears.
